// File: rtl/rs_symbol_encoder_pkg.sv
// Shared GF(16) definitions for the RS(8,6) encoder/decoder pair:
// field polynomial, generator taps, codeword geometry, encoder states, gf_mul.
package rs_symbol_encoder_pkg;

    localparam int         DATA_SYMS = 6;
    localparam int         PAR_SYMS  = 2;
    localparam int         SYM_W     = 4;
    localparam logic [4:0] PRIM_POLY = 5'b10011;   // x^4 + x + 1
    localparam logic [3:0] G1        = 4'd3;
    localparam logic [3:0] G0        = 4'd2;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAR1 = 2'd1,
        PAR0 = 2'd2
    } enc_state_e;

    // Shift-and-add multiply; with a constant operand this folds to a few XORs.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ PRIM_POLY[3:0]) : {x[2:0], 1'b0};
        end
        return acc;
    endfunction

endpackage

// File: rtl/rs_symbol_encoder_lfsr.sv
// Two-stage LFSR divider by g(x)=x^2+G1*x+G0; after six data shifts r1/r0
// hold the parity symbols p1/p0.
module rs_enc_lfsr
    import rs_symbol_encoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       shift,
    input  logic       clr,
    input  logic [3:0] sym_in,
    output logic [3:0] p1,
    output logic [3:0] p0
);

    logic [3:0] r1_q, r1_d;
    logic [3:0] r0_q, r0_d;
    logic [3:0] fb;

    always_comb begin
        fb   = sym_in ^ r1_q;
        r1_d = r1_q;
        r0_d = r0_q;
        if (clr) begin
            r1_d = '0;
            r0_d = '0;
        end else if (shift) begin
            r1_d = r0_q ^ gf_mul(fb, G1);
            r0_d = gf_mul(fb, G0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q <= '0;
            r0_q <= '0;
        end else begin
            r1_q <= r1_d;
            r0_q <= r0_d;
        end
    end

    assign p1 = r1_q;
    assign p0 = r0_q;

endmodule

// File: rtl/rs_symbol_encoder.sv
// Streaming systematic RS(8,6) encoder: forwards six data symbols, then p1, p0.
// Define RS_ENC_CW_OUT_EN to add the cw_valid/codeword capture port.
module rs_symbol_encoder
    import rs_symbol_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_sym,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_sym,
    output logic            out_last,
    output logic            out_is_par
`ifdef RS_ENC_CW_OUT_EN
    ,
    output logic            cw_valid,
    output logic [7:0][3:0] codeword
`endif
);

    enc_state_e state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_sym_q, out_sym_d;
    logic       out_last_q, out_last_d;
    logic       out_is_par_q, out_is_par_d;
    logic       load_ok, accept, lfsr_clr;
    logic [3:0] p1, p0;

`ifdef RS_ENC_CW_OUT_EN
    logic [23:0]     cw_data_q, cw_data_d;
    logic [7:0][3:0] codeword_q, codeword_d;
    logic            cw_valid_q, cw_valid_d;
`endif

    rs_enc_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .shift  (accept),
        .clr    (lfsr_clr),
        .sym_in (in_sym),
        .p1     (p1),
        .p0     (p0)
    );

    always_comb begin
        // Output stage can take a new symbol when empty or draining this cycle.
        load_ok      = !out_valid_q || out_ready;
        in_ready     = (state_q == DATA) && load_ok;
        accept       = in_valid && in_ready;
        lfsr_clr     = 1'b0;
        state_d      = state_q;
        count_d      = count_q;
        out_valid_d  = load_ok ? 1'b0 : out_valid_q;
        out_sym_d    = out_sym_q;
        out_last_d   = out_last_q;
        out_is_par_d = out_is_par_q;
`ifdef RS_ENC_CW_OUT_EN
        cw_data_d    = cw_data_q;
        codeword_d   = codeword_q;
        cw_valid_d   = 1'b0;
`endif
        case (state_q)
            DATA: if (accept) begin
                out_valid_d  = 1'b1;
                out_sym_d    = in_sym;
                out_last_d   = 1'b0;
                out_is_par_d = 1'b0;
`ifdef RS_ENC_CW_OUT_EN
                cw_data_d    = {cw_data_q[19:0], in_sym};
`endif
                if (count_q == 3'(DATA_SYMS - 1)) state_d = PAR1;
                else                              count_d = count_q + 3'd1;
            end
            PAR1: if (load_ok) begin
                out_valid_d  = 1'b1;
                out_sym_d    = p1;
                out_last_d   = 1'b0;
                out_is_par_d = 1'b1;
                state_d      = PAR0;
            end
            PAR0: if (load_ok) begin
                out_valid_d  = 1'b1;
                out_sym_d    = p0;
                out_last_d   = 1'b1;
                out_is_par_d = 1'b1;
                lfsr_clr     = 1'b1;
                count_d      = '0;
                state_d      = DATA;
`ifdef RS_ENC_CW_OUT_EN
                codeword_d   = {cw_data_q, p1, p0};
                cw_valid_d   = 1'b1;
`endif
            end
            default: state_d = DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DATA;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_sym_q    <= '0;
            out_last_q   <= 1'b0;
            out_is_par_q <= 1'b0;
`ifdef RS_ENC_CW_OUT_EN
            cw_data_q    <= '0;
            codeword_q   <= '0;
            cw_valid_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_sym_q    <= out_sym_d;
            out_last_q   <= out_last_d;
            out_is_par_q <= out_is_par_d;
`ifdef RS_ENC_CW_OUT_EN
            cw_data_q    <= cw_data_d;
            codeword_q   <= codeword_d;
            cw_valid_q   <= cw_valid_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sym    = out_sym_q;
    assign out_last   = out_last_q;
    assign out_is_par = out_is_par_q;
`ifdef RS_ENC_CW_OUT_EN
    assign cw_valid   = cw_valid_q;
    assign codeword   = codeword_q;
`endif

endmodule

// File: tb/tb_rs_symbol_encoder.sv
// Directed bench for rs_symbol_encoder: hand-computed parity vectors, stalls,
// mid-codeword reset and GF(16) syndrome checks on random data.
module tb_rs_symbol_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sym;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sym;
    logic       out_last;
    logic       out_is_par;

    int checks = 0;
    int errors = 0;
    bit rdy_rand = 1'b0;
    bit bub_en   = 1'b0;
    logic [5:0] got_q[$];   // {last, is_par, sym}
    int   acc = 0;
    bit   hold = 1'b0;
    logic [5:0] held;

    rs_symbol_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sym     (in_sym),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sym    (out_sym),
        .out_last   (out_last),
        .out_is_par (out_is_par)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] tb_gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return p;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Collects drained symbols, checks hold-while-stalled and in_ready during parity.
    always @(negedge clk) begin
        if (rst) begin
            got_q.delete();
            acc  = 0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_sym", 32'({out_last, out_is_par, out_sym}), 32'(held));
            end
            if (acc == 6 && !(out_valid && out_last)) chk("in_ready_par", 32'(in_ready), 0);
            if (out_valid && out_ready) got_q.push_back({out_last, out_is_par, out_sym});
            if (out_valid && out_ready && out_last) acc = 0;
            if (in_valid && in_ready) acc++;
            hold = out_valid && !out_ready;
            held = {out_last, out_is_par, out_sym};
        end
    end

    task automatic send_sym(input logic [3:0] s);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        if (bub_en && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_sym   = s;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else if (++n > 500) begin
                chk("accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cw(input logic [23:0] d);
        for (int i = 0; i < 6; i++) send_sym(d[23 - 4*i -: 4]);
    endtask

    task automatic wait_out(input string tag, input int n);
        int c;
        c = 0;
        while (got_q.size() < n && c < 3000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 32'(got_q.size()), 32'(n));
    endtask

    task automatic cmp_cw(input string tag, input int base, input logic [31:0] exp);
        if (got_q.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk({tag, "_sym"}, 32'(got_q[base+i][3:0]), 32'(exp[31 - 4*i -: 4]));
                chk({tag, "_par"}, 32'(got_q[base+i][4]), 32'(i >= 6));
                chk({tag, "_last"}, 32'(got_q[base+i][5]), 32'(i == 7));
            end
        end
    endtask

    task automatic syn_cw(input string tag, input logic [23:0] d);
        logic [3:0] s0, s1, pw, sym;
        logic [23:0] fwd;
        s0 = 0; s1 = 0; fwd = 0;
        for (int k = 0; k < 8; k++) begin
            sym = got_q[k][3:0];
            pw  = 4'd1;
            for (int j = 0; j < 7 - k; j++) pw = tb_gmul(pw, 4'd2);
            s0  = s0 ^ sym;
            s1  = s1 ^ tb_gmul(sym, pw);
            if (k < 6) fwd = {fwd[19:0], sym};
        end
        chk({tag, "_fwd"}, 32'(fwd), 32'(d));
        chk({tag, "_s0"}, 32'(s0), 0);
        chk({tag, "_s1"}, 32'(s1), 0);
    endtask

    initial begin
        logic [23:0] rd;
        rst = 1'b1; in_valid = 1'b0; in_sym = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sym", 32'(out_sym), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_par", 32'(out_is_par), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        send_cw(24'h000000); wait_out("zero_n", 8); cmp_cw("zero", 0, 32'h0000_0000);
        got_q.delete();
        send_cw(24'h100000); wait_out("d1_n", 8); cmp_cw("d1", 0, 32'h1000_0067);
        got_q.delete();
        send_cw(24'h000001); wait_out("d6_n", 8); cmp_cw("d6", 0, 32'h0000_0132);
        got_q.delete();
        send_cw(24'h000010); wait_out("d5_n", 8); cmp_cw("d5", 0, 32'h0000_1076);
        got_q.delete();
        send_cw(24'h100000); send_cw(24'h100000);
        wait_out("b2b_n", 16); cmp_cw("b2b_a", 0, 32'h1000_0067); cmp_cw("b2b_b", 8, 32'h1000_0067);
        got_q.delete();

        rdy_rand = 1'b1; bub_en = 1'b1;
        send_cw(24'h100000); send_cw(24'h000001); send_cw(24'h000010);
        wait_out("stall_n", 24);
        cmp_cw("stall_a", 0, 32'h1000_0067);
        cmp_cw("stall_b", 8, 32'h0000_0132);
        cmp_cw("stall_c", 16, 32'h0000_1076);
        rdy_rand = 1'b0; bub_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();

        send_sym(4'd1); send_sym(4'd2); send_sym(4'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_sym", 32'(out_sym), 0);
        chk("mid_rst_last", 32'(out_last), 0);
        chk("mid_rst_par", 32'(out_is_par), 0);
        rst = 1'b0;
        send_cw(24'h100000); wait_out("post_rst_n", 8); cmp_cw("post_rst", 0, 32'h1000_0067);
        got_q.delete();

        for (int t = 0; t < 4; t++) begin
            rd = 24'($urandom);
            send_cw(rd);
            wait_out("rnd_n", 8);
            if (got_q.size() >= 8) syn_cw("rnd", rd);
            got_q.delete();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_symbol_encoder.md
# rs_symbol_encoder

Streaming systematic Reed-Solomon RS(8,6) encoder over GF(16), the transmit-side counterpart of the decoder's syndrome/Berlekamp/Forney chain. Accepts six 4-bit data symbols per codeword on a valid/ready input. Forwards them unchanged, then appends the two parity symbols computed by an LFSR divider, all on a valid/ready output. The decoder's locator and magnitude logic corrects any single-symbol error in the 8-symbol codeword it emits.

## Interface
Parameters:
- DATA_SYMS, 6: data symbols per codeword; fixed, not overridable.
- PAR_SYMS, 2: parity symbols per codeword; fixed.

Ports:
- clk  in  1  single clock; everything on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  data symbol offered.
- in_ready  out  1  encoder accepts the symbol this cycle.
- in_sym  in  4  data symbol, GF(16) element.
- out_valid  out  1  output symbol valid.
- out_ready  in  1  downstream accepts the symbol.
- out_sym  out  4  codeword symbol.
- out_last  out  1  high with the final parity symbol, p0.
- out_is_par  out  1  high while out_sym is a parity symbol.

## Operation
- Field: GF(2^4), primitive polynomial x^4+x+1, alpha=2.
- Generator: g(x)=(x+1)(x+alpha)=x^2+3x+2, so G1=3 and G0=2.
- Codeword order: symbol 7 is sent first. Symbols 7..2 are data; symbol 1 is p1; symbol 0 is p0.
- LFSR registers r1 and r0, updated on each input handshake:
  - f = in_sym ^ r1
  - r1 <= r0 ^ gfmul(f,G1)
  - r0 <= gfmul(f,G0)
- After six data symbols: p1=r1, p0=r0, i.e. the remainder of d(x)·x^2 mod g(x).
- States:
  - DATA: accepts input; a 3-bit count of accepted symbols runs 0..5. Accepting the 6th symbol moves to PAR1.
  - PAR1: loads r1 into the output stage when the output stage is free, then moves to PAR0.
  - PAR0: loads r0 with out_last=1, clears r1, r0 and the count in the same cycle, then moves to DATA.
- in_ready = (state==DATA) && (!out_valid || out_ready). It is combinational and never high in PAR1 or PAR0.
- Output stage is a single register, loaded whenever it is empty or being drained that cycle.
- While out_valid=1 and out_ready=0, out_sym, out_last and out_is_par hold stable.
- Reset values: state=DATA, count=0, r1=r0=0, out_valid=0, out_sym=0, out_last=0, out_is_par=0.
- Reset mid-codeword discards the partial codeword and any held output symbol. The next accepted symbol starts a fresh codeword.
- An in_valid that is not accepted has no effect.
- Gaps are legal on both sides, any length, at any position.

## Timing
- Latency: an accepted data symbol appears on out_sym the next cycle.
- p1 is presented at the earliest one cycle after the 6th data symbol leaves the output stage; p0 follows one cycle later.
- With out_ready held at 1, a codeword takes 8 output cycles and the input is stalled for 2 cycles per codeword. Peak throughput is 6 data symbols per 8 cycles.
- The first data symbol of the next codeword may be accepted in the same cycle p0 is drained.
- Critical path: r1 -> XOR -> constant gfmul -> XOR -> r1.

## Configuration
- RS_ENC_CW_OUT_EN:
  - Defined: adds output cw_valid (1 bit) and output codeword (8x4 bits, index 7..0 as above).
  - codeword holds all 8 symbols of the last completed codeword.
  - cw_valid pulses for one cycle when p0 is loaded into the output stage.
  - Both reset to 0.
  - Lets the decoder be driven directly in loopback benches.
- Undefined: these ports and their 32-bit capture register do not exist. Streaming behaviour is identical either way.

## Structure
- Shared GF(16) package (same as the decoder side) holds:
  - the primitive polynomial;
  - constants G1=3 and G0=2;
  - DATA_SYMS and PAR_SYMS;
  - the state enum (DATA, PAR1, PAR0);
  - a gf_mul function.
- One sub-module, rs_enc_lfsr: holds r1 and r0, with shift, clear and the two parity outputs. Constant multipliers come from the shared GFMULT logic.
- The top holds the FSM, the count and the output stage.

## Test plan
- Data 0,0,0,0,0,0 with out_ready=1 -> out_sym 0 ×8; out_is_par=1 on the last two symbols; out_last on the 8th.
- Data 1,0,0,0,0,0 -> parity p1=6, p0=7.
- Data 0,0,0,0,0,1 -> p1=3, p0=2. Two back-to-back codewords 1,0,0,0,0,0 -> the second also gives 6,7, proving the LFSR clears.
- out_ready toggled randomly with in_valid bubbles -> output symbols held stable while stalled; no loss or duplication; in_ready=0 during PAR1/PAR0.
- rst asserted after 3 data symbols, then data 1,0,0,0,0,0 -> all outputs reset the next cycle; the fresh codeword gives 6,7.
- Random data looped through the decoder with one injected symbol error at each of the 8 positions -> original codeword recovered. With RS_ENC_CW_OUT_EN, codeword matches the streamed symbols and cw_valid pulses once.
